udsp_data_mem: RTL and testbench

UDSP_DATA_MEM -- requirements
Module: udsp_data_mem

---
 rtl/udsp_pkg.sv | 28 ++
 rtl/udsp_sdp_ram.sv | 27 ++
 rtl/udsp_data_mem.sv | 154 +++++++++++++++
 tb/tb_udsp_data_mem.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/udsp_pkg.sv
// udsp shared constants: memory geometry, segment map
// and core opcodes.
package udsp_pkg;

  localparam int DAW  = 10;
  localparam int DWW  = 36;
  localparam int HAW  = 7;
  localparam int SEGW = DAW - HAW;

  localparam logic [SEGW-1:0] SEG_IO = '0;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LD  = 4'h1,
    OP_ST  = 4'h2,
    OP_ADD = 4'h3,
    OP_SUB = 4'h4,
    OP_MUL = 4'h5,
    OP_MAC = 4'h6,
    OP_JMP = 4'h7
  } udsp_op_e;

  typedef struct packed {
    logic io;
    logic bnk;
  } rd_sel_t;

endpackage

// File: rtl/udsp_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered
// read port with enable. Read-before-write on collision.
module udsp_sdp_ram #(
  parameter int DEPTH = 128,
  parameter int AW    = 7,
  parameter int DW    = 36
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rd_q <= mem_q[raddr_i];
  end

  assign rdata_o = rd_q;

endmodule

// File: rtl/udsp_data_mem.sv
// udsp data memory: private core RAM plus two ping-pong
// I/O buffers shared between the core and the host.
module udsp_data_mem
  import udsp_pkg::rd_sel_t;
#(
  parameter int DAW = udsp_pkg::DAW,
  parameter int DWW = udsp_pkg::DWW,
  parameter int HAW = udsp_pkg::HAW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DAW-1:0] addrA,
  output logic [DWW-1:0] dataA,
  input  logic [DAW-1:0] addrB,
  output logic [DWW-1:0] dataB,
  input  logic [DAW-1:0] addrW,
  input  logic [DWW-1:0] dataW,
  input  logic           writeEn,
  input  logic           hostValid,
  output logic           hostReady,
  input  logic           hostWrite,
  input  logic [HAW-1:0] hostAddr,
  input  logic [DWW-1:0] hostWData,
  output logic [DWW-1:0] hostRData,
  output logic           hostRValid,
  input  logic           frameSwap,
  output logic           bank,
  output logic [15:0]    frameCount
);

  localparam int IOW = 1 << HAW;
  localparam int PVW = (1 << DAW) - IOW;
  localparam logic [DAW-1:0] PV_BASE = DAW'(IOW);

  logic          bank_q, bank_d;
  logic [15:0]   fcnt_q, fcnt_d;
  logic          live_q, rdy_q;
  rd_sel_t       asel_q, bsel_q;
  logic          hval_q, hsel_q, hlive_q;

  logic          aio, bio, wio;
  logic          hx, hw, hr, cw_io, cw_pv;
  logic [DAW-1:0] pa, pb, pw;
  logic [DWW-1:0] pva, pvb;
  logic [DWW-1:0] ioa [2];
  logic [DWW-1:0] iob [2];
  logic [DWW-1:0] ioh [2];

  assign aio = addrA[DAW-1:HAW] == udsp_pkg::SEG_IO;
  assign bio = addrB[DAW-1:HAW] == udsp_pkg::SEG_IO;
  assign wio = addrW[DAW-1:HAW] == udsp_pkg::SEG_IO;

  assign hx    = hostValid & rdy_q;
  assign hw    = hx & hostWrite;
  assign hr    = hx & ~hostWrite;
  assign cw_io = writeEn & wio;
  assign cw_pv = writeEn & ~wio;

  assign pa = addrA - PV_BASE;
  assign pb = addrB - PV_BASE;
  assign pw = addrW - PV_BASE;

  udsp_sdp_ram #(.DEPTH(PVW), .AW(DAW), .DW(DWW)) u_pv_a (
    .clk(clk), .we_i(cw_pv), .waddr_i(pw),
    .wdata_i(dataW), .re_i(1'b1), .raddr_i(pa),
    .rdata_o(pva)
  );

  udsp_sdp_ram #(.DEPTH(PVW), .AW(DAW), .DW(DWW)) u_pv_b (
    .clk(clk), .we_i(cw_pv), .waddr_i(pw),
    .wdata_i(dataW), .re_i(1'b1), .raddr_i(pb),
    .rdata_o(pvb)
  );

  // Core owns IO[bank], host owns IO[~bank]; writers never collide.
  for (genvar g = 0; g < 2; g++) begin : g_io
    logic           core_w, host_w, host_r, we;
    logic [HAW-1:0] wa;
    logic [DWW-1:0] wd;

    assign core_w = cw_io & (bank_q == 1'(g));
    assign host_w = hw & (bank_q != 1'(g));
    assign host_r = hr & (bank_q != 1'(g));
    assign we     = core_w | host_w;
    assign wa     = core_w ? addrW[HAW-1:0] : hostAddr;
    assign wd     = core_w ? dataW : hostWData;

    udsp_sdp_ram #(.DEPTH(IOW), .AW(HAW), .DW(DWW)) u_a (
      .clk(clk), .we_i(we), .waddr_i(wa),
      .wdata_i(wd), .re_i(1'b1),
      .raddr_i(addrA[HAW-1:0]), .rdata_o(ioa[g])
    );

    udsp_sdp_ram #(.DEPTH(IOW), .AW(HAW), .DW(DWW)) u_b (
      .clk(clk), .we_i(we), .waddr_i(wa),
      .wdata_i(wd), .re_i(1'b1),
      .raddr_i(addrB[HAW-1:0]), .rdata_o(iob[g])
    );

    udsp_sdp_ram #(.DEPTH(IOW), .AW(HAW), .DW(DWW)) u_h (
      .clk(clk), .we_i(we), .waddr_i(wa),
      .wdata_i(wd), .re_i(host_r),
      .raddr_i(hostAddr), .rdata_o(ioh[g])
    );
  end

  always_comb begin
    bank_d = bank_q ^ frameSwap;
    fcnt_d = fcnt_q + 16'(frameSwap);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q  <= 1'b0;
      fcnt_q  <= '0;
      live_q  <= 1'b0;
      rdy_q   <= 1'b0;
      asel_q  <= '0;
      bsel_q  <= '0;
      hval_q  <= 1'b0;
      hsel_q  <= 1'b0;
      hlive_q <= 1'b0;
    end else begin
      bank_q  <= bank_d;
      fcnt_q  <= fcnt_d;
      live_q  <= 1'b1;
      rdy_q   <= 1'b1;
      asel_q  <= '{io: aio, bnk: bank_q};
      bsel_q  <= '{io: bio, bnk: bank_q};
      hval_q  <= hr;
      if (hr) begin
        hsel_q  <= ~bank_q;
        hlive_q <= 1'b1;
      end
    end
  end

  always_comb begin
    dataA     = '0;
    dataB     = '0;
    hostRData = '0;
    if (live_q) begin
      dataA = asel_q.io ? ioa[asel_q.bnk] : pva;
      dataB = bsel_q.io ? iob[bsel_q.bnk] : pvb;
    end
    if (hlive_q) hostRData = ioh[hsel_q];
  end

  assign hostReady  = rdy_q;
  assign hostRValid = hval_q;
  assign bank       = bank_q;
  assign frameCount = fcnt_q;

endmodule

// File: tb/tb_udsp_data_mem.sv
// Scoreboard bench for udsp_data_mem: directed core,
// host and frame-swap vectors.
module tb_udsp_data_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  addrA = '0, addrB = '0, addrW = '0;
  logic [35:0] dataA, dataB;
  logic [35:0] dataW = '0;
  logic        writeEn = 1'b0;
  logic        hostValid = 1'b0, hostWrite = 1'b0;
  logic        hostReady, hostRValid;
  logic [6:0]  hostAddr = '0;
  logic [35:0] hostWData = '0, hostRData;
  logic        frameSwap = 1'b0;
  logic        bank;
  logic [15:0] frameCount;

  udsp_data_mem dut (
    .clk(clk), .rst(rst),
    .addrA(addrA), .dataA(dataA),
    .addrB(addrB), .dataB(dataB),
    .addrW(addrW), .dataW(dataW), .writeEn(writeEn),
    .hostValid(hostValid), .hostReady(hostReady),
    .hostWrite(hostWrite), .hostAddr(hostAddr),
    .hostWData(hostWData), .hostRData(hostRData),
    .hostRValid(hostRValid),
    .frameSwap(frameSwap), .bank(bank),
    .frameCount(frameCount)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          due;
    string       nm;
    logic [35:0] ea;
    logic [35:0] eb;
  } cexp_t;

  typedef struct {
    string       nm;
    logic [35:0] ed;
  } hexp_t;

  cexp_t cq[$];
  hexp_t hq[$];

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Monitor: core reads by due cycle, host reads on hostRValid.
  always @(negedge clk) begin
    cexp_t ce;
    hexp_t he;
    if (cq.size() > 0 && cq[0].due <= cyc) begin
      ce = cq.pop_front();
      chk({ce.nm, "_A"}, 64'(dataA), 64'(ce.ea));
      chk({ce.nm, "_B"}, 64'(dataB), 64'(ce.eb));
    end
    if (hostRValid) begin
      if (hq.size() == 0) begin
        chk("host_spurious_rvalid", 64'd1, 64'd0);
      end else begin
        he = hq.pop_front();
        chk(he.nm, 64'(hostRData), 64'(he.ed));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic crd(input logic [9:0] a, input logic [9:0] b,
                     input logic [35:0] ea,
                     input logic [35:0] eb, input string nm);
    addrA = a;
    addrB = b;
    cq.push_back('{due: cyc + 1, nm: nm, ea: ea, eb: eb});
    step();
  endtask

  task automatic cwr(input logic [9:0] a,
                     input logic [35:0] d);
    writeEn = 1'b1;
    addrW = a;
    dataW = d;
    step();
    writeEn = 1'b0;
  endtask

  task automatic hwr(input logic [6:0] a,
                     input logic [35:0] d);
    hostValid = 1'b1;
    hostWrite = 1'b1;
    hostAddr = a;
    hostWData = d;
    step();
    hostValid = 1'b0;
    hostWrite = 1'b0;
  endtask

  task automatic hrd(input logic [6:0] a,
                     input logic [35:0] e, input string nm);
    hostValid = 1'b1;
    hostWrite = 1'b0;
    hostAddr = a;
    hq.push_back('{nm: nm, ed: e});
    step();
    hostValid = 1'b0;
  endtask

  task automatic swap1();
    frameSwap = 1'b1;
    step();
    frameSwap = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_bank", 64'(bank), 64'd0);
    chk("rst_fcnt", 64'(frameCount), 64'd0);
    chk("rst_dataA", 64'(dataA), 64'd0);
    chk("rst_dataB", 64'(dataB), 64'd0);
    chk("rst_hrdata", 64'(hostRData), 64'd0);
    chk("rst_hrvalid", 64'(hostRValid), 64'd0);
    chk("rst_hready", 64'(hostReady), 64'd0);
    step();
    step();
    rst = 1'b0;
    chk("hready_pre_edge", 64'(hostReady), 64'd0);
    step();
    chk("hready_post_edge", 64'(hostReady), 64'd1);

    // Swap together with a host write: lands in IO1.
    frameSwap = 1'b1;
    hostValid = 1'b1;
    hostWrite = 1'b1;
    hostAddr = 7'd1;
    hostWData = 36'h54;
    step();
    frameSwap = 1'b0;
    hostValid = 1'b0;
    hostWrite = 1'b0;
    chk("swap_hw_bank", 64'(bank), 64'd1);
    chk("swap_hw_fcnt", 64'(frameCount), 64'd1);
    crd(10'h001, 10'h001, 36'h54, 36'h54, "io1_w1");

    cwr(10'h085, 36'h123456789);
    crd(10'h085, 10'h085, 36'h123456789,
        36'h123456789, "wr_then_rd");

    cwr(10'h085, 36'h1);
    writeEn = 1'b1;
    addrW = 10'h085;
    dataW = 36'h5;
    crd(10'h085, 10'h085, 36'h1, 36'h1, "rd_old");
    writeEn = 1'b0;
    crd(10'h085, 10'h085, 36'h5, 36'h5, "rd_new");

    cwr(10'h3FF, 36'hFFFFFFFFF);
    cwr(10'h080, 36'h0A5A5A5A5);
    crd(10'h080, 10'h3FF, 36'h0A5A5A5A5,
        36'hFFFFFFFFF, "pv_bounds");

    // Read sampled at the swap edge sees pre-swap IO1.
    frameSwap = 1'b1;
    crd(10'h001, 10'h001, 36'h54, 36'h54, "swap_pre_rd");
    frameSwap = 1'b0;
    chk("bank_back0", 64'(bank), 64'd0);

    hwr(7'd3, 36'hABC);
    swap1();
    crd(10'h003, 10'h001, 36'hABC, 36'h54, "host_to_core");

    swap1();
    cwr(10'h010, 36'h77);
    crd(10'h010, 10'h010, 36'h77, 36'h77, "io0_rd");
    swap1();
    chk("fcnt5", 64'(frameCount), 64'd5);
    hrd(7'h10, 36'h77, "core_to_host");
    step();
    chk("hrvalid_drop", 64'(hostRValid), 64'd0);
    chk("hrdata_hold", 64'(hostRData), 64'h77);

    frameSwap = 1'b1;
    step();
    chk("b2b_1", 64'(bank), 64'd0);
    step();
    chk("b2b_2", 64'(bank), 64'd1);
    step();
    chk("b2b_3", 64'(bank), 64'd0);
    chk("b2b_fcnt", 64'(frameCount), 64'd8);

    repeat (65527) step();
    chk("wrap_pre_fcnt", 64'(frameCount), 64'hFFFF);
    chk("wrap_pre_bank", 64'(bank), 64'd1);
    step();
    frameSwap = 1'b0;
    chk("wrap_fcnt", 64'(frameCount), 64'd0);
    chk("wrap_bank", 64'(bank), 64'd0);

    // Reset right after a host read is accepted.
    swap1();
    hostValid = 1'b1;
    hostWrite = 1'b0;
    hostAddr = 7'h10;
    step();
    hostValid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_rvalid", 64'(hostRValid), 64'd0);
    chk("mid_rst_bank", 64'(bank), 64'd0);
    chk("mid_rst_fcnt", 64'(frameCount), 64'd0);
    chk("mid_rst_ready", 64'(hostReady), 64'd0);
    chk("mid_rst_dataA", 64'(dataA), 64'd0);
    chk("mid_rst_hrdata", 64'(hostRData), 64'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_rvalid", 64'(hostRValid), 64'd0);
    end

    crd(10'h010, 10'h085, 36'h77, 36'h5, "keep_io0_pv");
    crd(10'h3FF, 10'h080, 36'hFFFFFFFFF,
        36'h0A5A5A5A5, "keep_pv");
    hrd(7'd1, 36'h54, "keep_io1_a1");
    hrd(7'd3, 36'hABC, "keep_io1_a3");
    step();
    step();
    chk("core_q_empty", 64'(cq.size()), 64'd0);
    chk("host_q_empty", 64'(hq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
